route_sequencer: RTL and testbench

// - Issues per-node turn commands to the turn executor. Debounces raw node detection, then

---
 rtl/sm_nav_pkg.sv | 16 +
 rtl/route_sequencer_if.sv | 42 ++++
 rtl/level_debounce.sv | 45 ++++
 rtl/route_sequencer.sv | 157 +++++++++++++++
 tb/tb_route_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_nav_pkg.sv
// Shared navigation constants: turn direction codes and the sequencer state
// encoding. The turn executor uses the same direction codes.
package sm_nav_pkg;

    localparam logic [1:0] DIR_STRAIGHT = 2'd3;
    localparam logic [1:0] DIR_RIGHT    = 2'd2;
    localparam logic [1:0] DIR_LEFT     = 2'd1;
    localparam logic [1:0] DIR_UTURN    = 2'd0;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        TURN   = 2'd1,
        CLEAR  = 2'd2
    } state_t;

endpackage

// File: rtl/route_sequencer_if.sv
// Signal bundle between the route sequencer and its environment: the
// line-sensor node flag, the turn executor handshake, and the route status.
interface route_sequencer_if;
    import sm_nav_pkg::*;

    // Handshake: node acts as the request (valid) and turn_done as the
    // completion (ready). node rises with direction already stable and holds
    // both until turn_done is sampled high. node then drops on the next cycle,
    // and stays low for at least one cycle so the executor can reset. A
    // turn_done that is still high after node has dropped has no effect.
    logic       node_det;
    logic       turn_done;
    logic       node;
    logic [1:0] direction;
    logic [4:0] node_count;
    logic [1:0] lap;
    logic       fault;
    state_t     state;

    modport master (
        input  node_det,
        input  turn_done,
        output node,
        output direction,
        output node_count,
        output lap,
        output fault,
        output state
    );

    modport slave (
        output node_det,
        output turn_done,
        input  node,
        input  direction,
        input  node_count,
        input  lap,
        input  fault,
        input  state
    );

endinterface

// File: rtl/level_debounce.sv
// Synchronises an asynchronous level and confirms it after N consecutive
// samples equal to LEVEL. The count is held at zero while i_enable is low, so
// a confirmation window always starts fresh when its user becomes interested.
module level_debounce #(
    parameter int   N     = 4,
    parameter logic LEVEL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    input  logic i_enable,
    output logic o_confirmed
);

    // Wide enough to hold N itself, the value the counter saturates at.
    localparam int             CW    = $clog2(N + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(N);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;

    // Two-flop synchroniser for the raw level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    // Consecutive-sample counter; any off-level sample restarts it.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable || (r_sync2 != LEVEL)) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_confirmed = (r_cnt == LIMIT);

endmodule

// File: rtl/route_sequencer.sv
// Route sequencer: confirms each node, issues the turn for the current route
// entry to the turn executor, waits for completion (or times out), and re-arms
// only after the robot has clearly left the node. Tracks route position and
// completed laps.
module route_sequencer
    import sm_nav_pkg::*;
#(
    parameter int                   ROUTE_LEN    = 8,
    parameter logic [2*ROUTE_LEN-1:0] ROUTE      = 16'hFEDB,
    parameter int                   DEBOUNCE     = 50000,
    parameter int                   CLEAR_CYCLES = 2500000,
    parameter int                   TURN_TIMEOUT = 150000000
) (
    input  logic               clk_50,
    input  logic               rst,
    route_sequencer_if.master  bus
);

    localparam logic [27:0] TMO_LAST  = 28'(TURN_TIMEOUT - 1);
    localparam logic [4:0]  LAST_NODE = 5'(ROUTE_LEN - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_node;
    logic [1:0]  r_direction;
    logic [4:0]  r_node_count;
    logic [1:0]  r_lap;
    logic        r_fault;
    logic [27:0] r_tmo_cnt;

    logic        w_rise_en;
    logic        w_fall_en;
    logic        w_rise_conf;
    logic        w_fall_conf;
    logic        w_timeout;
    logic        w_take_dir;
    logic        w_advance;
    logic        w_set_fault;
    logic [1:0]  w_route_dir;

    assign w_rise_en = (r_state == FOLLOW);
    assign w_fall_en = (r_state == CLEAR);

    level_debounce #(.N(DEBOUNCE), .LEVEL(1'b1)) u_rise (
        .i_clk       (clk_50),
        .i_rst       (rst),
        .i_async     (bus.node_det),
        .i_enable    (w_rise_en),
        .o_confirmed (w_rise_conf)
    );

    level_debounce #(.N(CLEAR_CYCLES), .LEVEL(1'b0)) u_fall (
        .i_clk       (clk_50),
        .i_rst       (rst),
        .i_async     (bus.node_det),
        .i_enable    (w_fall_en),
        .o_confirmed (w_fall_conf)
    );

    // Route table lookup for the current position in the lap.
    always_comb begin
        w_route_dir = DIR_STRAIGHT;
        for (int i = 0; i < ROUTE_LEN; i++) begin
            if (r_node_count == 5'(i)) begin
                w_route_dir = ROUTE[2*i +: 2];
            end
        end
    end

    // The timeout counter holds the number of completed TURN cycles, so this
    // fires on the last permitted cycle.
    assign w_timeout = (r_tmo_cnt == TMO_LAST);

    // Next-state and step decisions; turn_done takes priority over timeout.
    always_comb begin
        w_next_state = r_state;
        w_take_dir   = 1'b0;
        w_advance    = 1'b0;
        w_set_fault  = 1'b0;
        case (r_state)
            FOLLOW: begin
                if (w_rise_conf) begin
                    w_next_state = TURN;
                    w_take_dir   = 1'b1;
                end
            end
            TURN: begin
                if (bus.turn_done) begin
                    w_next_state = CLEAR;
                    w_advance    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = CLEAR;
                    w_set_fault  = 1'b1;
                end
            end
            CLEAR: begin
                if (w_fall_conf) begin
                    w_next_state = FOLLOW;
                end
            end
            default: w_next_state = FOLLOW;
        endcase
    end

    // State register; node is its own flop so the request never glitches.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state <= FOLLOW;
            r_node  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_node  <= (w_next_state == TURN);
        end
    end

    // Direction latch, route position, lap count and sticky fault.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_direction  <= DIR_STRAIGHT;
            r_node_count <= '0;
            r_lap        <= '0;
            r_fault      <= 1'b0;
        end else begin
            if (w_take_dir) begin
                r_direction <= w_route_dir;
            end
            if (w_advance) begin
                if (r_node_count == LAST_NODE) begin
                    r_node_count <= '0;
                    r_lap        <= r_lap + 2'd1;
                end else begin
                    r_node_count <= r_node_count + 5'd1;
                end
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Saturating count of cycles spent in TURN; zero elsewhere.
    always_ff @(posedge clk_50) begin
        if (rst || (r_state != TURN)) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != '1) begin
            r_tmo_cnt <= r_tmo_cnt + 28'd1;
        end
    end

    assign bus.node       = r_node;
    assign bus.direction  = r_direction;
    assign bus.node_count = r_node_count;
    assign bus.lap        = r_lap;
    assign bus.fault      = r_fault;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_route_sequencer.sv
// Bench for route_sequencer with small limits: directed node/turn/exit
// sequences, a cycle-level behavioural model compared every cycle, an
// expected-direction queue checked on each request, and literal expectations.
module tb_route_sequencer;
    import sm_nav_pkg::*;

    localparam int         TB_LEN = 3;
    localparam logic [5:0] TB_ROUTE = 6'b00_01_10;
    localparam int         TB_DEB = 4;
    localparam int         TB_CLR = 8;
    localparam int         TB_TMO = 64;

    localparam int M_FOLLOW = 0;
    localparam int M_TURN   = 1;
    localparam int M_CLEAR  = 2;

    logic clk_50;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic chk_en;

    route_sequencer_if bus();

    route_sequencer #(
        .ROUTE_LEN    (TB_LEN),
        .ROUTE        (TB_ROUTE),
        .DEBOUNCE     (TB_DEB),
        .CLEAR_CYCLES (TB_CLR),
        .TURN_TIMEOUT (TB_TMO)
    ) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    // ---------------- behavioural model ----------------
    logic [1:0] exp_q[$];
    int         m_mode;
    int         m_run;
    int         m_tcyc;
    int         m_cnt;
    int         m_lap;
    logic [1:0] m_dir;
    logic       m_fault;
    logic       m_node;
    logic [1:0] m_syn;
    logic       m_seen;

    function automatic logic [1:0] route_entry(input int idx);
        logic [5:0] r;
        r = TB_ROUTE;
        return r[2*idx +: 2];
    endfunction

    initial begin
        m_mode = M_FOLLOW; m_run = 0; m_tcyc = 0; m_cnt = 0; m_lap = 0;
        m_dir = 2'd3; m_fault = 1'b0; m_node = 1'b0; m_syn = 2'b00;
    end

    always @(posedge clk_50) begin
        m_seen = m_syn[1];
        if (rst) begin
            m_mode = M_FOLLOW; m_run = 0; m_tcyc = 0; m_cnt = 0; m_lap = 0;
            m_dir = 2'd3; m_fault = 1'b0; m_syn = 2'b00;
        end else begin
            case (m_mode)
                M_FOLLOW: begin
                    if (m_run == TB_DEB) begin
                        m_mode = M_TURN;
                        m_tcyc = 0;
                        m_dir  = route_entry(m_cnt);
                        exp_q.push_back(m_dir);
                    end else begin
                        m_run = m_seen ? m_run + 1 : 0;
                    end
                end
                M_TURN: begin
                    if (bus.turn_done) begin
                        m_mode = M_CLEAR;
                        m_run  = 0;
                        m_cnt  = (m_cnt + 1) % TB_LEN;
                        if (m_cnt == 0) m_lap = (m_lap + 1) % 4;
                    end else if (m_tcyc == TB_TMO - 1) begin
                        m_mode  = M_CLEAR;
                        m_run   = 0;
                        m_fault = 1'b1;
                    end else begin
                        m_tcyc = m_tcyc + 1;
                    end
                end
                default: begin
                    if (m_run == TB_CLR) begin
                        m_mode = M_FOLLOW;
                        m_run  = 0;
                    end else begin
                        m_run = !m_seen ? m_run + 1 : 0;
                    end
                end
            endcase
            m_syn = {m_syn[0], bus.node_det};
        end
        m_node = (m_mode == M_TURN);
    end

    // ---------------- scoreboard / compare ----------------
    logic        prev_node;
    logic [10:0] got_v;
    logic [10:0] exp_v;
    logic [1:0]  exp_dir;

    initial prev_node = 1'b0;

    always @(negedge clk_50) begin
        if (chk_en) begin
            got_v = {bus.node, bus.direction, bus.node_count, bus.lap, bus.fault};
            exp_v = {m_node, m_dir, 5'(m_cnt), 2'(m_lap), m_fault};
            n_checks++;
            if (got_v === exp_v) n_pass++;
            else $display("FAIL cycle_model t=%0t got node/dir/cnt/lap/fault=%b required=%b",
                          $time, got_v, exp_v);
            if (bus.node === 1'b1 && prev_node === 1'b0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL dir_queue t=%0t got request dir=%0d required none pending",
                             $time, bus.direction);
                end else begin
                    exp_dir = exp_q.pop_front();
                    if (bus.direction === exp_dir) n_pass++;
                    else $display("FAIL dir_queue t=%0t got=%0d required=%0d",
                                  $time, bus.direction, exp_dir);
                end
            end
        end
        prev_node = bus.node;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s got=%0d required=%0d", name, got, req);
    endtask

    task automatic wait_node(input logic level, input int max_cyc, output int cyc);
        cyc = 0;
        while (bus.node !== level && cyc < max_cyc) begin
            @(negedge clk_50);
            cyc++;
        end
        if (bus.node !== level) begin
            n_checks++;
            $display("FAIL wait_node got node=%b required=%b within %0d cycles",
                     bus.node, level, max_cyc);
        end
    endtask

    task automatic no_node_for(input int n, input string name);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk_50);
            seen = seen | bus.node;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic full_node(input logic [1:0] req_dir, input string name);
        int c;
        bus.node_det = 1'b1;
        wait_node(1'b1, 30, c);
        check(name, 32'(bus.direction), 32'(req_dir));
        tick(2);
        bus.node_det = 1'b0;
        tick(1);
        bus.turn_done = 1'b1;
        tick(1);
        bus.turn_done = 1'b0;
        tick(12);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int c;
        n_checks = 0;
        n_pass   = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        bus.node_det  = 1'b0;
        bus.turn_done = 1'b0;
        tick(3);
        rst    = 1'b0;
        chk_en = 1'b1;

        // reset state
        check("rst_node", 32'(bus.node), 32'd0);
        check("rst_dir", 32'(bus.direction), 32'd3);
        check("rst_count", 32'(bus.node_count), 32'd0);
        check("rst_lap", 32'(bus.lap), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_state", 32'(bus.state), 32'(FOLLOW));

        // Test 1: confirm latency and turn_done latency
        bus.node_det = 1'b1;
        wait_node(1'b1, 20, c);
        check("t1_latency", 32'(c), 32'd7);
        check("t1_dir", 32'(bus.direction), 32'd2);
        tick(3);
        bus.node_det = 1'b0;
        tick(2);
        bus.turn_done = 1'b1;
        tick(1);
        bus.turn_done = 1'b0;
        check("t1_node_drop", 32'(bus.node), 32'd0);
        check("t1_count", 32'(bus.node_count), 32'd1);
        tick(15);
        check("t1_back_follow", 32'(bus.state), 32'(FOLLOW));

        // Test 2: short glitches are rejected
        bus.node_det = 1'b1; tick(3);
        bus.node_det = 1'b0; tick(1);
        bus.node_det = 1'b1; tick(3);
        bus.node_det = 1'b0;
        no_node_for(12, "t2_no_request");
        check("t2_dir_kept", 32'(bus.direction), 32'd2);

        // Test 3: one full lap
        do_reset();
        full_node(2'd2, "t3_dir0");
        full_node(2'd1, "t3_dir1");
        full_node(2'd0, "t3_dir2");
        check("t3_count_wrap", 32'(bus.node_count), 32'd0);
        check("t3_lap", 32'(bus.lap), 32'd1);

        // Test 4: robot lingers on the node; held turn_done is ignored
        bus.node_det = 1'b1;
        wait_node(1'b1, 20, c);
        check("t4_dir_first", 32'(bus.direction), 32'd2);
        bus.turn_done = 1'b1;
        tick(4);
        bus.turn_done = 1'b0;
        check("t4_node_drop", 32'(bus.node), 32'd0);
        check("t4_count_once", 32'(bus.node_count), 32'd1);
        no_node_for(20, "t4_held_high");
        bus.node_det = 1'b0; tick(5);
        bus.node_det = 1'b1;
        no_node_for(15, "t4_short_low");
        bus.node_det = 1'b0;
        tick(12);
        full_node(2'd1, "t4_dir_next");

        // Test 5: turn timeout sets sticky fault, position kept
        bus.node_det = 1'b1;
        wait_node(1'b1, 20, c);
        check("t5_dir", 32'(bus.direction), 32'd0);
        wait_node(1'b0, 100, c);
        check("t5_turn_len", 32'(c), 32'd64);
        check("t5_fault", 32'(bus.fault), 32'd1);
        check("t5_count_kept", 32'(bus.node_count), 32'd2);
        bus.node_det = 1'b0;
        tick(12);
        full_node(2'd0, "t5_retry_dir");
        check("t5_count_wrap", 32'(bus.node_count), 32'd0);
        check("t5_lap", 32'(bus.lap), 32'd2);
        check("t5_fault_sticky", 32'(bus.fault), 32'd1);
        do_reset();
        check("t5_fault_rst", 32'(bus.fault), 32'd0);

        // Test 6: reset mid-turn, then turn_done on the timeout cycle
        full_node(2'd2, "t6_pre_dir");
        bus.node_det = 1'b1;
        wait_node(1'b1, 20, c);
        rst = 1'b1;
        tick(1);
        check("t6_rst_node", 32'(bus.node), 32'd0);
        check("t6_rst_count", 32'(bus.node_count), 32'd0);
        rst = 1'b0;
        bus.node_det = 1'b0;
        tick(4);
        bus.node_det = 1'b1;
        wait_node(1'b1, 20, c);
        tick(63);
        bus.turn_done = 1'b1;
        tick(1);
        bus.turn_done = 1'b0;
        check("t6_tie_fault", 32'(bus.fault), 32'd0);
        check("t6_tie_node", 32'(bus.node), 32'd0);
        check("t6_tie_count", 32'(bus.node_count), 32'd1);
        bus.node_det = 1'b0;
        tick(12);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
